// File: rtl/multdiv_sequencer_pkg.sv
// Shared constants for the multiply/divide sequencer: datapath width,
// iteration counter sizing and FSM state encodings.
package multdiv_sequencer_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] ITER_LAST = 5'd31;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_MULT      = 3'd1;
  localparam logic [2:0] S_DIV_ABS_A = 3'd2;
  localparam logic [2:0] S_DIV_ABS_B = 3'd3;
  localparam logic [2:0] S_DIV_ITER  = 3'd4;
  localparam logic [2:0] S_DIV_FIX   = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

endpackage

// File: rtl/multdiv_sequencer_iter_counter.sv
// Iteration counter: synchronous clear, count enable, and a flag that is
// high while the count sits on the last iteration.
module multdiv_sequencer_iter_counter
  import multdiv_sequencer_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == ITER_LAST);

endmodule

// File: rtl/multdiv_sequencer.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring) controller
// that borrows the execute stage's shared adder for one pass per cycle.
module multdiv_sequencer
  import multdiv_sequencer_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] adder_operandA,
  output logic [WIDTH-1:0] adder_operandB,
  output logic             adder_subtraction,
  input  logic [WIDTH-1:0] adder_result,
  input  logic             adder_overflow,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy,
  output logic [2:0]       state_dbg
);

  // Handshake: a ctrl_* level is taken only on an edge where the FSM is in
  // IDLE or DONE (MULT has priority); data_resultRDY is a single-cycle pulse
  // in DONE, during which data_result/data_exception are valid and a new
  // start may be presented for back-to-back operation.

  logic [2:0]       state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic             q_1;
  logic             s_a;
  logic             s_b;
  logic [WIDTH-1:0] result_r;
  logic             exc_r;

  logic             start;
  logic             cnt_tc;
  logic             booth_op;
  logic [WIDTH-1:0] booth_sum;
  logic             booth_ext;
  logic [WIDTH-1:0] acc_sh;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH:0]   rs;
  logic             take;

  assign start = ((state == S_IDLE) || (state == S_DONE)) && (ctrl_MULT || ctrl_DIV);

  multdiv_sequencer_iter_counter u_iter_counter (
    .clock (clock),
    .reset (reset),
    .clr   (start),
    .en    ((state == S_MULT) || (state == S_DIV_ITER)),
    .tc    (cnt_tc)
  );

  // Booth step: the true sign of the 33-bit partial sum comes from the
  // adder's overflow flag, since M = -2^31 can overflow the 32-bit add.
  assign booth_op  = q[0] ^ q_1;
  assign booth_sum = booth_op ? adder_result : acc;
  assign booth_ext = booth_op ? (adder_result[WIDTH-1] ^ adder_overflow) : acc[WIDTH-1];
  assign acc_sh    = {booth_ext, booth_sum[WIDTH-1:1]};
  assign q_sh      = {booth_sum[0], q[WIDTH-1:1]};

  assign rs   = {acc, q[WIDTH-1]};
  assign take = rs[WIDTH] | (rs[WIDTH-1:0] >= m);

  always_comb begin
    adder_operandA    = '0;
    adder_operandB    = '0;
    adder_subtraction = 1'b0;
    case (state)
      S_MULT: begin
        adder_operandA    = acc;
        adder_operandB    = m;
        adder_subtraction = q[0] & ~q_1;
      end
      S_DIV_ABS_A: if (s_a) begin
        adder_operandB    = q;
        adder_subtraction = 1'b1;
      end
      S_DIV_ABS_B: if (s_b) begin
        adder_operandB    = m;
        adder_subtraction = 1'b1;
      end
      S_DIV_ITER: begin
        adder_operandA    = rs[WIDTH-1:0];
        adder_operandB    = m;
        adder_subtraction = 1'b1;
      end
      S_DIV_FIX: if (s_a ^ s_b) begin
        adder_operandB    = q;
        adder_subtraction = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      acc      <= '0;
      q        <= '0;
      m        <= '0;
      q_1      <= 1'b0;
      s_a      <= 1'b0;
      s_b      <= 1'b0;
      result_r <= '0;
      exc_r    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (ctrl_MULT) begin
            m        <= data_operandA;
            q        <= data_operandB;
            acc      <= '0;
            q_1      <= 1'b0;
            result_r <= '0;
            exc_r    <= 1'b0;
            state    <= S_MULT;
          end else if (ctrl_DIV) begin
            // Dividend lives in q, divisor in m, partial remainder in acc.
            m        <= data_operandB;
            q        <= data_operandA;
            acc      <= '0;
            q_1      <= 1'b0;
            s_a      <= data_operandA[WIDTH-1];
            s_b      <= data_operandB[WIDTH-1];
            result_r <= '0;
            if (data_operandB == '0) begin
              exc_r <= 1'b1;
              state <= S_DONE;
            end else begin
              exc_r <= 1'b0;
              state <= S_DIV_ABS_A;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_MULT: begin
          acc <= acc_sh;
          q   <= q_sh;
          q_1 <= q[0];
          if (cnt_tc) begin
            result_r <= q_sh;
            exc_r    <= (acc_sh != {WIDTH{q_sh[WIDTH-1]}});
            state    <= S_DONE;
          end
        end
        S_DIV_ABS_A: begin
          if (s_a) q <= adder_result;
          state <= S_DIV_ABS_B;
        end
        S_DIV_ABS_B: begin
          if (s_b) m <= adder_result;
          state <= S_DIV_ITER;
        end
        S_DIV_ITER: begin
          acc <= take ? adder_result : rs[WIDTH-1:0];
          q   <= {q[WIDTH-2:0], take};
          if (cnt_tc) state <= S_DIV_FIX;
        end
        S_DIV_FIX: begin
          // Only -2^31 / -1 yields a magnitude that cannot be a positive result.
          result_r <= (s_a ^ s_b) ? adder_result : q;
          exc_r    <= (q == {1'b1, {(WIDTH-1){1'b0}}}) && (s_a == s_b);
          state    <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign data_result    = result_r;
  assign data_exception = exc_r;
  assign data_resultRDY = (state == S_DONE);
  assign busy           = (state != S_IDLE) && (state != S_DONE);
  assign state_dbg      = state;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: a behavioural shared adder, a driver
// task per operation, and a monitor that pops expected results on each RDY.
module tb_multdiv_sequencer;

  logic        clock;
  logic        reset;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] adder_operandA;
  logic [31:0] adder_operandB;
  logic        adder_subtraction;
  logic [31:0] adder_result;
  logic        adder_overflow;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];
  logic [32:0] exp_v;
  logic        prev_rdy = 1'b0;

  multdiv_sequencer dut (
    .clock             (clock),
    .reset             (reset),
    .ctrl_MULT         (ctrl_MULT),
    .ctrl_DIV          (ctrl_DIV),
    .data_operandA     (data_operandA),
    .data_operandB     (data_operandB),
    .adder_operandA    (adder_operandA),
    .adder_operandB    (adder_operandB),
    .adder_subtraction (adder_subtraction),
    .adder_result      (adder_result),
    .adder_overflow    (adder_overflow),
    .data_result       (data_result),
    .data_exception    (data_exception),
    .data_resultRDY    (data_resultRDY),
    .busy              (busy),
    .state_dbg         (state_dbg)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1);
  end

  // Shared adder: two's complement add/subtract with signed overflow.
  logic [31:0] b_eff;
  assign b_eff          = adder_subtraction ? ~adder_operandB : adder_operandB;
  assign adder_result   = adder_operandA + b_eff + {31'b0, adder_subtraction};
  assign adder_overflow = (adder_operandA[31] == b_eff[31]) && (adder_result[31] != adder_operandA[31]);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    if (data_resultRDY) begin
      chk("rdy_single_cycle", {31'b0, prev_rdy}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rdy: got result %h, expected no result", data_result);
      end else begin
        exp_v = exp_q.pop_front();
        chk("result", data_result, exp_v[31:0]);
        chk("exception", {31'b0, data_exception}, {31'b0, exp_v[32]});
      end
    end
    prev_rdy = data_resultRDY;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // op: 0 = MULT, 1 = DIV, 2 = both ctrls. Returns in the RDY cycle.
  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_exc,
                        input int exp_lat, input int pulse_at);
    int n;
    exp_q.push_back({exp_exc, exp_res});
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT = (op != 1);
    ctrl_DIV  = (op != 0);
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    if (exp_lat > 0) begin
      chk("busy_after_start", {31'b0, busy}, 32'd1);
      chk("state_after_start", {29'b0, state_dbg}, (op == 1) ? 32'd2 : 32'd1);
    end else begin
      chk("divzero_state", {29'b0, state_dbg}, 32'd6);
      chk("divzero_adder_a", adder_operandA, 32'd0);
      chk("divzero_adder_b", adder_operandB, 32'd0);
      chk("divzero_adder_sub", {31'b0, adder_subtraction}, 32'd0);
    end
    n = 0;
    while (!data_resultRDY && n < 100) begin
      @(posedge clock);
      #1;
      n++;
      ctrl_DIV = (n == pulse_at);
    end
    ctrl_DIV = 1'b0;
    chk("latency", n, exp_lat);
    chk("busy_at_rdy", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    reset         = 1'b0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    #2;
    chk("rst_result", data_result, 32'd0);
    chk("rst_exception", {31'b0, data_exception}, 32'd0);
    chk("rst_rdy", {31'b0, data_resultRDY}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_state", {29'b0, state_dbg}, 32'd0);
    chk("rst_adder_a", adder_operandA, 32'd0);
    chk("rst_adder_b", adder_operandB, 32'd0);
    chk("rst_adder_sub", {31'b0, adder_subtraction}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    idle(2);

    // Multiply
    run_op(0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 32, -1); idle(2);
    run_op(0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 32, -1); idle(2);
    run_op(0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 32, -1); idle(2);
    run_op(0, 32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b1, 32, -1); idle(2);

    // Divide
    run_op(1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 1'b0, 35, -1); idle(2);
    run_op(1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0, 35, -1); idle(2);
    run_op(1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'h0000000E, 1'b0, 35, -1); idle(2);
    run_op(1, 32'd1000,     32'd10,       32'h00000064, 1'b0, 35, -1); idle(2);
    run_op(1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 35, -1); idle(2);
    run_op(1, 32'd5,        32'd0,        32'h00000000, 1'b1, 0,  -1); idle(2);

    // DIV pulse mid-MULT is ignored; next MULT starts from DONE; both ctrls -> MULT
    run_op(0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 32, 10);
    run_op(0, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'h00000019, 1'b0, 32, -1);
    run_op(2, 32'd3,        32'd4,        32'h0000000C, 1'b0, 32, -1); idle(2);

    // Reset mid-divide aborts with no result
    data_operandA = 32'hFFFFFF9C;
    data_operandB = 32'd7;
    ctrl_DIV = 1'b1;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    repeat (15) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_result", data_result, 32'd0);
    chk("abort_rdy", {31'b0, data_resultRDY}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_state", {29'b0, state_dbg}, 32'd0);
    chk("abort_adder_a", adder_operandA, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    idle(45);
    run_op(0, 32'd6, 32'd7, 32'h0000002A, 1'b0, 32, -1);
    idle(4);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Multi-cycle signed multiply/divide controller. It owns no adder of its own.
- It sequences the processor's shared 32-bit carry-lookahead adder through a combinational operand/result interface: one adder pass per cycle.
- Sits beside the ALU in the execute stage.
- Provides MULT/DIV results with a one-cycle ready pulse and an exception flag.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported.
- CNT_W, 5, iteration counter width (log2 WIDTH).

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ctrl_MULT  in  1  start-multiply pulse
- ctrl_DIV  in  1  start-divide pulse
- data_operandA  in  32  multiplicand / dividend, sampled at start
- data_operandB  in  32  multiplier / divisor, sampled at start
- adder_operandA  out  32  shared adder operand A
- adder_operandB  out  32  shared adder operand B, before the adder's internal negate
- adder_subtraction  out  1  1 = A-B, 0 = A+B
- adder_result  in  32  shared adder sum, combinational, same cycle
- adder_overflow  in  1  shared adder signed overflow
- data_result  out  32  low 32 bits of product, or quotient
- data_exception  out  1  overflow or divide-by-zero; valid with data_resultRDY
- data_resultRDY  out  1  one-cycle result-valid pulse
- busy  out  1  high in every state except IDLE and DONE

Behaviour:
- Reset (reset=0, async): state=IDLE; all registers cleared; all outputs 0. Reset mid-operation aborts it with no RDY pulse.
- States: IDLE, MULT, DIV_ABS_A, DIV_ABS_B, DIV_ITER, DIV_FIX, DONE.
- Start: ctrl_* is sampled only in IDLE or DONE, so back-to-back starts are allowed from DONE.
  - ctrl_* in any other state is ignored.
  - If ctrl_MULT and ctrl_DIV are both set, MULT wins.
- Adder port defaults: in IDLE and DONE, drive adder_operandA = adder_operandB = 0 and adder_subtraction = 0.
- Multiply (radix-2 Booth, signed). Call the start edge E0.
  - E0: M=A, Q=B, ACC=0, q_1=0, cnt=0.
  - Each MULT cycle drives adder A=ACC, B=M, sub=(Q[0]==1 && q_1==0).
  - sum = adder_result if Q[0]!=q_1, else ACC.
  - ext = adder_result[31]^adder_overflow if an add/sub was selected, else ACC[31].
  - Shift: {ACC,Q,q_1} <= {ext, sum, Q} arithmetic-shifted right by 1 (65 bits).
  - After 32 iterations (edge E32): DONE; data_result = Q.
  - data_exception = 1 if ACC != {32{Q[31]}}.
- Divide (restoring on magnitudes, signed). E0 latches sA = A[31], sB = B[31].
  - B==0 at E0: go directly to DONE with data_result=0, data_exception=1, so RDY is high the cycle after E0.
  - DIV_ABS_A (E1): if sA, drive 0-A and latch |A|. DIV_ABS_B (E2): same for B.
  - DIV_ITER (E3..E34), 32 passes: Rs = {R,Q[31]} (33-bit); drive adder A=Rs[31:0], B=|B|, sub=1.
  - If Rs[32] | (Rs[31:0] >= |B|, unsigned), take R=adder_result and shift in quotient bit 1. Otherwise R=Rs[31:0] and shift in quotient bit 0.
  - DIV_FIX (E35): if sA^sB, drive 0-Q and latch it; otherwise pass Q.
  - Exception: magnitude quotient 0x80000000 with sA==sB (-2^31 / -1) gives data_result=0x80000000, data_exception=1.
- Latency: RDY is high the cycle after E32 (MULT), E35 (DIV), or E0 (divide-by-zero).
- DONE behaviour:
  - data_result and data_exception hold until the next start.
  - data_resultRDY is high for exactly one cycle, then DONE→IDLE, unless a new ctrl_* is present.
- Remainder sign is not produced; the remainder is discarded.

Decomposition:
- Shared package: state encoding localparams, WIDTH, CNT_W, ITER_LAST=31.
- One natural sub-module, iter_counter: CNT_W-bit up-counter with synchronous clear and a terminal-count flag.
- The shared adder stays outside this block; the ALU top muxes its inputs by busy.

Test Plan:
- MULT A=7, B=-3 → data_result=0xFFFFFFEB, exception=0, RDY exactly one cycle, after edge E32; busy high E1..E32.
- MULT 0x00010000 × 0x00010000 → data_result=0x00000000, exception=1. MULT 0x80000000 × 0x80000000 → result 0, exception=1 (exercises the adder_overflow ext path).
- DIV -100 / 7 → data_result=0xFFFFFFF2 (-14), exception=0, RDY after E35. DIV 100 / -7 → 0xFFFFFFF2. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, exception=1.
- DIV 5 / 0 → data_result=0, exception=1, RDY the cycle after the start edge; no adder activity (adder ports stay 0).
- Pulse ctrl_DIV at E10 during a MULT → ignored, MULT result unchanged. Assert ctrl_MULT on the DONE cycle → new op starts with no idle gap. Both ctrls in one cycle → multiply.
- Drop reset at E15 of a DIV → all outputs 0 immediately, state IDLE, no RDY. A following MULT 6×7 → 42.
